sfty_diag_seq: RTL and testbench
================================

# sfty_diag_seq

Safety-diagnostic sequencer that drives the dual-rail diagnostic mode into the comparator error-injection controller, runs one complete injection sweep per request, and collects the comparator responses. It produces a pass/fail verdict, a per-comparator fail vector and sticky fault flags. It sits between the safety register block and the injection controller/comparator bank.

## Interface
- NUM_COMPARATORS, 4, number of lockstep comparators; injection mask width MASK_SIZE = 2*NUM_COMPARATORS
- CMP_LATENCY, 2, cycles from mask bit to comparator error output; drain length (1..7)
- TIMEOUT_CYCLES, 32, max INJECT cycles without inj_end; must exceed MASK_SIZE
- PERIOD_CYCLES, 1024, auto-start interval (used only with SFTY_DIAG_PERIODIC_EN)
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- diag_start  in  1  request one diagnostic sweep (pulse, sampled in IDLE only)
- dr_sfty_diag_inj_end  in  2  dual-rail injection-complete from injection controller
- dr_mask_pty_err  in  2  dual-rail mask parity error from injection controller
- cmp_err  in  NUM_COMPARATORS  comparator error outputs
- dr_sfty_diag_mode_sc  out  2  dual-rail diag mode to injection controller (2'b10 inject, 2'b01 normal)
- diag_busy  out  1  sweep in progress
- diag_done  out  1  one-cycle pulse, results valid
- diag_pass  out  1  last sweep passed
- diag_fail_vec  out  NUM_COMPARATORS  comparators that never flagged during last sweep
- diag_timeout  out  1  last sweep hit timeout
- diag_pty_fail  out  1  parity error seen during last sweep
- dr_seq_err  out  2  dual-rail sticky input-encoding fault (2'b10 fault)

## Operation
- Dual-rail: 2'b01 = false, 2'b10 = true; 2'b00/2'b11 invalid.
- States: IDLE, INJECT, DRAIN, REPORT. All outputs registered.
- IDLE: mode 2'b01, busy 0. diag_start=1 -> INJECT; clear hit vector, pty and timeout accumulators, timeout counter.
- INJECT: mode 2'b10, busy 1. Each cycle: hit |= cmp_err; pty |= (dr_mask_pty_err==2'b10); timeout counter +1. inj_end==2'b10 -> DRAIN. Counter reaching TIMEOUT_CYCLES-1 without inj_end -> DRAIN with timeout set.
- DRAIN: mode 2'b01, busy 1, CMP_LATENCY cycles; hit |= cmp_err continues; parity not sampled.
- REPORT: one cycle; diag_done=1; diag_fail_vec = ~hit; diag_pass = (hit all ones) & !pty & !timeout; diag_timeout/diag_pty_fail updated -> IDLE. Result outputs hold until next REPORT or reset.
- Comparator i covered by mask bits 2i and 2i+1; each must flag at least once.
- Invalid encoding on either dual-rail input in any state sets dr_seq_err=2'b10 sticky until rst; does not alter the sweep.
- diag_start outside IDLE ignored, not queued.
- rst: state IDLE, mode 2'b01, busy 0, done 0, pass 0, fail_vec 0, timeout 0, pty_fail 0, dr_seq_err 2'b01, counters 0. Reset mid-sweep abandons it with no done pulse.
- Invalid state encoding -> IDLE next cycle.

## Timing
- diag_start in IDLE at cycle T: INJECT at T+1 (mode 2'b10 from T+1).
- Injection controller counts from 0 at T+1; inj_end seen at T+MASK_SIZE; DRAIN T+MASK_SIZE+1 .. T+MASK_SIZE+CMP_LATENCY; diag_done at T+MASK_SIZE+CMP_LATENCY+1. Defaults: done at T+11.
- Back-to-back: next diag_start accepted the cycle after REPORT (IDLE).
- Timeout path: done at T+TIMEOUT_CYCLES+CMP_LATENCY+1.

## Configuration
- SFTY_DIAG_PERIODIC_EN defined: free-running period counter (width $clog2(PERIOD_CYCLES)) counts in all states, wraps at PERIOD_CYCLES-1 and raises an internal start; internal start OR diag_start triggers from IDLE; internal start outside IDLE is dropped. Counter reset to 0 by rst.
- Undefined: no period counter; only diag_start triggers; PERIOD_CYCLES unused.

## Test plan
- Nominal: diag_start at T, model asserts cmp_err[i] at T+1+2i+CMP_LATENCY -> done at T+11, pass=1, fail_vec=4'b0000, timeout=0.
- Stuck comparator: cmp_err[2] held 0 -> done at T+11, pass=0, fail_vec=4'b0100.
- Timeout: inj_end held 2'b01 -> mode 2'b10 for 32 cycles, done at T+35, timeout=1, pass=0.
- Parity: dr_mask_pty_err=2'b10 for one INJECT cycle -> pty_fail=1, pass=0; 2'b11 on inj_end in IDLE -> dr_seq_err=2'b10 until rst.
- Reset mid-sweep at T+5 -> next cycle mode 2'b01, busy 0, no done; new start completes normally.
- With SFTY_DIAG_PERIODIC_EN, PERIOD_CYCLES=16, no diag_start -> done pulses every 16 cycles.

Source files
------------

// File: rtl/sfty_diag_seq.sv
// Safety-diagnostic sequencer. It drives the dual-rail diag mode to the injection
// controller, runs one injection sweep per start, and collects comparator responses.
// Optional periodic auto-start is enabled by defining SFTY_DIAG_PERIODIC_EN.
module sfty_diag_seq #(
   parameter int unsigned NUM_COMPARATORS = 4,
   parameter int unsigned CMP_LATENCY     = 2,
   parameter int unsigned TIMEOUT_CYCLES  = 32,
   parameter int unsigned PERIOD_CYCLES   = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       diag_start,
   input  logic [1:0]                 dr_sfty_diag_inj_end,
   input  logic [1:0]                 dr_mask_pty_err,
   input  logic [NUM_COMPARATORS-1:0] cmp_err,
   output logic [1:0]                 dr_sfty_diag_mode_sc,
   output logic                       diag_busy,
   output logic                       diag_done,
   output logic                       diag_pass,
   output logic [NUM_COMPARATORS-1:0] diag_fail_vec,
   output logic                       diag_timeout,
   output logic                       diag_pty_fail,
   output logic [1:0]                 dr_seq_err
);

   localparam int unsigned MASK_SIZE = 2 * NUM_COMPARATORS;
   // One counter serves both the INJECT timeout and the DRAIN length
   localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) > 3) ? $clog2(TIMEOUT_CYCLES) : 3;

   localparam logic [1:0] DR_TRUE  = 2'b10;
   localparam logic [1:0] DR_FALSE = 2'b01;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      INJECT = 2'b01,
      DRAIN  = 2'b10,
      REPORT = 2'b11
   } state_t;

   // Reject parameter sets the sequencing cannot support
   if (TIMEOUT_CYCLES <= MASK_SIZE) begin : g_chk_timeout
      $error("TIMEOUT_CYCLES must exceed MASK_SIZE");
   end
   if (CMP_LATENCY < 1 || CMP_LATENCY > 7) begin : g_chk_latency
      $error("CMP_LATENCY must be 1..7");
   end
   if (PERIOD_CYCLES < 2) begin : g_chk_period
      $error("PERIOD_CYCLES must be at least 2");
   end

   state_t                     state, state_nxt;
   logic [NUM_COMPARATORS-1:0] hit, hit_nxt;
   logic                       pty, pty_nxt;
   logic                       tmo, tmo_nxt;
   logic [CNT_W-1:0]           cnt, cnt_nxt;
   logic                       start_c;
   logic                       enc_bad_c;

`ifdef SFTY_DIAG_PERIODIC_EN
   localparam int unsigned PER_W = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
   logic [PER_W-1:0] per_cnt;
   logic             per_start_c;

   assign per_start_c = (per_cnt == PER_W'(PERIOD_CYCLES - 1));
   assign start_c     = diag_start | per_start_c;

   // Free-running period counter; its wrap is the internal start request
   always_ff @(posedge clk) begin
      if (rst)              per_cnt <= '0;
      else if (per_start_c) per_cnt <= '0;
      else                  per_cnt <= per_cnt + PER_W'(1);
   end
`else
   assign start_c = diag_start;
`endif

   // Both dual-rail inputs must always carry 01 or 10
   assign enc_bad_c = (dr_sfty_diag_inj_end[1] == dr_sfty_diag_inj_end[0]) |
                      (dr_mask_pty_err[1] == dr_mask_pty_err[0]);

   // Next-state and accumulator update
   always_comb begin
      state_nxt = state;
      hit_nxt   = hit;
      pty_nxt   = pty;
      tmo_nxt   = tmo;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (start_c) begin
               state_nxt = INJECT;
               hit_nxt   = '0;
               pty_nxt   = 1'b0;
               tmo_nxt   = 1'b0;
               cnt_nxt   = '0;
            end
         end
         INJECT: begin
            hit_nxt = hit | cmp_err;
            pty_nxt = pty | (dr_mask_pty_err == DR_TRUE);
            cnt_nxt = cnt + CNT_W'(1);
            if (dr_sfty_diag_inj_end == DR_TRUE) begin
               state_nxt = DRAIN;
               cnt_nxt   = '0;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_nxt = DRAIN;
               tmo_nxt   = 1'b1;
               cnt_nxt   = '0;
            end
         end
         DRAIN: begin
            hit_nxt = hit | cmp_err;
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_W'(CMP_LATENCY - 1)) state_nxt = REPORT;
         end
         REPORT: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, accumulators and registered outputs (derived from the next state)
   always_ff @(posedge clk) begin
      if (rst) begin
         state                <= IDLE;
         hit                  <= '0;
         pty                  <= 1'b0;
         tmo                  <= 1'b0;
         cnt                  <= '0;
         dr_sfty_diag_mode_sc <= DR_FALSE;
         diag_busy            <= 1'b0;
         diag_done            <= 1'b0;
         diag_pass            <= 1'b0;
         diag_fail_vec        <= '0;
         diag_timeout         <= 1'b0;
         diag_pty_fail        <= 1'b0;
         dr_seq_err           <= DR_FALSE;
      end else begin
         state                <= state_nxt;
         hit                  <= hit_nxt;
         pty                  <= pty_nxt;
         tmo                  <= tmo_nxt;
         cnt                  <= cnt_nxt;
         dr_sfty_diag_mode_sc <= (state_nxt == INJECT) ? DR_TRUE : DR_FALSE;
         diag_busy            <= (state_nxt != IDLE);
         diag_done            <= (state_nxt == REPORT);
         if (state_nxt == REPORT) begin
            diag_fail_vec <= ~hit_nxt;
            diag_pass     <= (&hit_nxt) & ~pty_nxt & ~tmo_nxt;
            diag_timeout  <= tmo_nxt;
            diag_pty_fail <= pty_nxt;
         end
         if (enc_bad_c) dr_seq_err <= DR_TRUE;
      end
   end

endmodule

// File: tb/tb_sfty_diag_seq.sv
// Directed bench for sfty_diag_seq with default parameters (4 comparators, latency 2, timeout 32).
module tb_sfty_diag_seq;

   logic       clk;
   logic       rst;
   logic       diag_start;
   logic [1:0] inj_end;
   logic [1:0] pty_err;
   logic [3:0] cmp_err;
   logic [1:0] mode;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] fail_vec;
   logic       timeout;
   logic       pty_fail;
   logic [1:0] seq_err;

   int checks = 0;
   int errors = 0;

   sfty_diag_seq dut (
      .clk                  (clk),
      .rst                  (rst),
      .diag_start           (diag_start),
      .dr_sfty_diag_inj_end (inj_end),
      .dr_mask_pty_err      (pty_err),
      .cmp_err              (cmp_err),
      .dr_sfty_diag_mode_sc (mode),
      .diag_busy            (busy),
      .diag_done            (done),
      .diag_pass            (pass),
      .diag_fail_vec        (fail_vec),
      .diag_timeout         (timeout),
      .diag_pty_fail        (pty_fail),
      .dr_seq_err           (seq_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      diag_start = 1'b0;
      inj_end    = 2'b01;
      pty_err    = 2'b01;
      cmp_err    = 4'b0000;
   endtask

   // One sweep started at cycle T; the loop body runs in cycle T+c.
   // A stray diag_start at T+5 must be ignored.
   task automatic sweep(input int stuck, input bit no_end, input int pty_cyc, input int done_cyc);
      int inj_len;
      inj_len    = no_end ? 32 : 8;
      diag_start = 1'b1;
      tick();
      for (int c = 1; c <= done_cyc; c++) begin
         chk($sformatf("mode_c%0d", c), 32'(mode), (c <= inj_len) ? 32'h2 : 32'h1);
         chk($sformatf("busy_c%0d", c), 32'(busy), 32'h1);
         chk($sformatf("done_c%0d", c), 32'(done), (c == done_cyc) ? 32'h1 : 32'h0);
         diag_start = (c == 5);
         inj_end    = (!no_end && c == 8) ? 2'b10 : 2'b01;
         pty_err    = (c == pty_cyc) ? 2'b10 : 2'b01;
         cmp_err    = 4'b0000;
         for (int i = 0; i < 4; i++)
            if (i != stuck && c == 3 + 2 * i) cmp_err[i] = 1'b1;
         if (c < done_cyc) tick();
      end
      idle_inputs();
      tick();
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_done", 32'(done), 32'h0);
      chk("idle_mode", 32'(mode), 32'h1);
   endtask

   task automatic results(input string tag, input logic p, input logic [3:0] fv,
                          input logic to, input logic pf);
      chk({tag, "_pass"}, 32'(pass), 32'(p));
      chk({tag, "_fail_vec"}, 32'(fail_vec), 32'(fv));
      chk({tag, "_timeout"}, 32'(timeout), 32'(to));
      chk({tag, "_pty_fail"}, 32'(pty_fail), 32'(pf));
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      // Reset values
      chk("rst_mode", 32'(mode), 32'h1);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      results("rst", 1'b0, 4'b0000, 1'b0, 1'b0);
      chk("rst_seq_err", 32'(seq_err), 32'h1);
      rst = 1'b0;
      tick();

      // Nominal sweep, then a back-to-back sweep with comparator 2 stuck
      sweep(-1, 1'b0, 0, 11);
      results("nominal", 1'b1, 4'b0000, 1'b0, 1'b0);
      sweep(2, 1'b0, 0, 11);
      results("stuck2", 1'b0, 4'b0100, 1'b0, 1'b0);

      // Injection controller never reports completion
      sweep(-1, 1'b1, 0, 35);
      results("timeout", 1'b0, 4'b0000, 1'b1, 1'b0);

      // Mask parity error during one INJECT cycle
      sweep(-1, 1'b0, 4, 11);
      results("parity", 1'b0, 4'b0000, 1'b0, 1'b1);
      chk("parity_seq_err", 32'(seq_err), 32'h1);

      // Invalid dual-rail encoding in IDLE is sticky and does not disturb sweeps
      inj_end = 2'b11;
      tick();
      inj_end = 2'b01;
      tick();
      chk("enc_seq_err", 32'(seq_err), 32'h2);
      chk("enc_busy", 32'(busy), 32'h0);
      sweep(-1, 1'b0, 0, 11);
      results("after_enc", 1'b1, 4'b0000, 1'b0, 1'b0);
      chk("enc_seq_err_sticky", 32'(seq_err), 32'h2);

      // Reset in the middle of a sweep abandons it without a done pulse
      diag_start = 1'b1;
      tick();
      diag_start = 1'b0;
      for (int c = 1; c < 5; c++) tick();
      chk("mid_busy_pre", 32'(busy), 32'h1);
      rst = 1'b1;
      tick();
      chk("mid_mode", 32'(mode), 32'h1);
      chk("mid_busy", 32'(busy), 32'h0);
      chk("mid_seq_err", 32'(seq_err), 32'h1);
      chk("mid_pass", 32'(pass), 32'h0);
      rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         chk($sformatf("mid_nodone_%0d", c), 32'(done), 32'h0);
      end
      sweep(-1, 1'b0, 0, 11);
      results("post_rst", 1'b1, 4'b0000, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
